// File: rtl/rs_param_station.sv
// Reservation station for ALU ops: CDB wakeup, oldest-ready-first issue.
// Age is a DEPTH x DEPTH matrix; older[i][j]=1 means entry j predates entry i.
module rs_param_station #(
   parameter int DEPTH    = 4,
   parameter int XLEN     = 32,
   parameter int OP_W     = 5,
   parameter int TAG_W    = 4,
   parameter int TAG_BASE = 1
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [OP_W-1:0]          disp_op,
   input  logic [XLEN-1:0]          disp_addr,
   input  logic [XLEN-1:0]          disp_vj,
   input  logic [XLEN-1:0]          disp_vk,
   input  logic [TAG_W-1:0]         disp_qj,
   input  logic [TAG_W-1:0]         disp_qk,
   output logic [TAG_W-1:0]         disp_tag,
   input  logic                     cdb_valid,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [XLEN-1:0]          cdb_val,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic [TAG_W-1:0]         issue_tag,
   output logic [OP_W-1:0]          issue_op,
   output logic [XLEN-1:0]          issue_addr,
   output logic [XLEN-1:0]          issue_vj,
   output logic [XLEN-1:0]          issue_vk,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int IW = $clog2(DEPTH);
   localparam int OW = IW + 1;

   logic [DEPTH-1:0] busy;
   logic [OP_W-1:0]  op_q   [DEPTH];
   logic [XLEN-1:0]  addr_q [DEPTH];
   logic [XLEN-1:0]  vj_q   [DEPTH];
   logic [XLEN-1:0]  vk_q   [DEPTH];
   logic [TAG_W-1:0] qj_q   [DEPTH];
   logic [TAG_W-1:0] qk_q   [DEPTH];
   logic [DEPTH-1:0] older  [DEPTH];

   logic [DEPTH-1:0] ready_vec;
   logic             free_any, sel_any;
   logic [IW-1:0]    free_idx, sel_idx;
   logic             cdb_hit, disp_fire, issue_fire;
   logic             byp_j, byp_k;

   always_comb begin
      free_any  = 1'b0;
      free_idx  = '0;
      sel_any   = 1'b0;
      sel_idx   = '0;
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++)
         ready_vec[i] = busy[i] && qj_q[i] == '0 && qk_q[i] == '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_any = 1'b1;
            free_idx = IW'(i);
         end
      end
      // Exactly one ready entry has no ready entry older than itself.
      for (int i = 0; i < DEPTH; i++) begin
         if (ready_vec[i] && (ready_vec & older[i]) == '0) begin
            sel_any = 1'b1;
            sel_idx = IW'(i);
         end
      end
   end

   assign cdb_hit    = cdb_valid && cdb_tag != '0;
   assign byp_j      = cdb_hit && disp_qj == cdb_tag;
   assign byp_k      = cdb_hit && disp_qk == cdb_tag;
   assign disp_ready = rdy_in && free_any;
   assign disp_tag   = disp_ready ? TAG_W'(TAG_BASE) + TAG_W'(free_idx) : '0;
   assign disp_fire  = disp_valid && disp_ready && !flush_in;
   assign issue_valid = rdy_in && sel_any;
   assign issue_fire  = issue_valid && issue_ready && !flush_in;

   assign issue_tag  = issue_valid ? TAG_W'(TAG_BASE) + TAG_W'(sel_idx) : '0;
   assign issue_op   = issue_valid ? op_q[sel_idx]   : '0;
   assign issue_addr = issue_valid ? addr_q[sel_idx] : '0;
   assign issue_vj   = issue_valid ? vj_q[sel_idx]   : '0;
   assign issue_vk   = issue_valid ? vk_q[sel_idx]   : '0;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy      <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= '0;
            addr_q[i] <= '0;
            vj_q[i]   <= '0;
            vk_q[i]   <= '0;
            qj_q[i]   <= '0;
            qk_q[i]   <= '0;
            older[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (flush_in) begin
            busy      <= '0;
            occupancy <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (busy[i] && cdb_hit) begin
                  if (qj_q[i] == cdb_tag) begin
                     vj_q[i] <= cdb_val;
                     qj_q[i] <= '0;
                  end
                  if (qk_q[i] == cdb_tag) begin
                     vk_q[i] <= cdb_val;
                     qk_q[i] <= '0;
                  end
               end
            end
            if (issue_fire)
               busy[sel_idx] <= 1'b0;
            if (disp_fire) begin
               busy[free_idx]   <= 1'b1;
               op_q[free_idx]   <= disp_op;
               addr_q[free_idx] <= disp_addr;
               vj_q[free_idx]   <= byp_j ? cdb_val : disp_vj;
               vk_q[free_idx]   <= byp_k ? cdb_val : disp_vk;
               qj_q[free_idx]   <= byp_j ? '0 : disp_qj;
               qk_q[free_idx]   <= byp_k ? '0 : disp_qk;
               for (int j = 0; j < DEPTH; j++)
                  older[j][free_idx] <= 1'b0;
               older[free_idx] <= busy;
            end
            occupancy <= occupancy + OW'(disp_fire) - OW'(issue_fire);
         end
      end
   end
endmodule

// File: doc/rs_param_station.md
Name: rs_param_station

Overview:
Parametrised reservation station for non-load/store ALU instructions. It holds up to DEPTH waiting instructions, each tagged for renaming. Entries wake up from the common data bus (CDB) and issue oldest-ready-first to an external ALU over a valid/ready handshake. The block sits between the dispatch stage (with regfile operand read) and the ALU/ROB writeback path, and supports a full flush on branch mispredict.

Parameters:
DEPTH, 4, number of entries (2..16)
XLEN, 32, operand/address width
OP_W, 5, opcode width
TAG_W, 4, rename tag width; tag value 0 means "None" (operand ready)
TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i; TAG_BASE>=1 and TAG_BASE+DEPTH-1 < 2^TAG_W

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low = freeze
flush_in  in  1  discard all entries (mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  a free entry exists
disp_op  in  OP_W  ALU opcode
disp_addr  in  XLEN  instruction PC
disp_vj, disp_vk  in  XLEN  operand values (vk already muxed with imm by dispatcher)
disp_qj, disp_qk  in  TAG_W  producer tags, 0 = value valid
disp_tag  out  TAG_W  tag that the accepted instruction receives this cycle (0 if disp_ready=0)
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAG_W  broadcast producer tag
cdb_val  in  XLEN  broadcast value
issue_valid  out  1  an entry is ready
issue_ready  in  1  ALU accepts
issue_tag  out  TAG_W  tag of issued entry
issue_op  out  OP_W  opcode
issue_addr, issue_vj, issue_vk  out  XLEN  PC and operands
occupancy  out  clog2(DEPTH)+1  number of busy entries

Behaviour:
- Reset (rst_in=0, async): all entries not busy, age state cleared. Outputs: issue_valid=0, occupancy=0, disp_ready=1, disp_tag=TAG_BASE, all issue data outputs 0.
- rdy_in=0: no state change; disp_ready=0, issue_valid=0. CDB broadcasts in frozen cycles are lost; the producer must hold or repeat them.
- Entry state: busy, op, addr, vj, vk, qj, qk, plus dispatch-order age. An entry is ready when busy && qj==0 && qk==0.
- Dispatch: disp_ready = rdy_in && any entry free (registered state only; a slot freed by issue in the same cycle is not reusable until next cycle). Free slot = lowest free index. disp_tag = TAG_BASE + that index; it is valid combinationally so the dispatcher can rename rd. A transfer occurs when disp_valid && disp_ready && !flush_in.
- Dispatch bypass: if cdb_valid and disp_qj==cdb_tag (tag nonzero), the entry stores vj=cdb_val, qj=0. The same rule applies to qk/vk. Without this bypass the entry would deadlock.
- Wakeup: on cdb_valid, every busy entry with qj==cdb_tag captures vj=cdb_val, qj=0; the same for qk. An entry woken in cycle t is eligible to issue at t+1, never in t.
- Issue select: among ready entries, pick the oldest by dispatch order. Ties are impossible. issue_* outputs are combinational from registered state. The entry is cleared on issue_valid && issue_ready. issue_ready low holds the same selection only if no older entry becomes ready; selection may change while stalled, and the ALU must not assume stability without a handshake.
- Age tracking: DEPTH×DEPTH age matrix, or equivalent. A new entry is younger than all busy entries. Age must survive arbitrary interleaving, with no sequence-number wrap errors.
- Simultaneous events in one cycle: dispatch, wakeup, and issue to different entries all take effect. The issued entry is popped even if the CDB matches it. occupancy_next = occupancy + dispatch − issue.
- Flush: when flush_in=1 (and rdy_in=1), all entries are cleared next cycle and dispatch/issue in that cycle are ignored. issue_valid is still shown but the handshake is void; the ALU must gate with flush_in. Flush has priority over everything.
- Full: occupancy==DEPTH → disp_ready=0, disp_tag=0. Empty: issue_valid=0, issue outputs 0.
- cdb_tag==0 never matches anything.

Test Plan:
- Reset, then dispatch op=ADD, qj=qk=0, vj=5, vk=7 with DEPTH=4, TAG_BASE=1 → disp_tag=1. Next cycle issue_valid=1, issue_tag=1, vj=5, vk=7; issue_ready=1 → occupancy 1→0.
- Dispatch A(qj=6), B(ready), C(qj=6) with issue_ready=0, then CDB tag=6 val=0x10 → B issues first, then A, then C, each with vj=0x10. Confirm age order A before C.
- Dispatch 4 entries with qj=9 → disp_ready=0, disp_tag=0, occupancy=4. Issue one after CDB tag 9; the freed slot is reused next cycle with tag TAG_BASE+freed_index.
- Dispatch qk=3 in the same cycle as cdb tag=3 val=0xABCD → the entry issues the next cycle with vk=0xABCD (bypass check).
- Fill 3 entries, assert flush_in along with disp_valid → occupancy=0 next cycle, no dispatch accepted. Assert rst_in=0 mid-cycle → outputs clear immediately, without waiting for a clock edge.
- rdy_in=0 for 3 cycles with disp_valid=1, issue_ready=1 → no state change, disp_ready=0, issue_valid=0.
